mm_shift_arbiter: RTL and testbench
===================================

# mm_shift_arbiter

Shares a single registered 128-bit SSE-style byte-shift unit between `NUM_REQ` requesters in the minimap2 alignment datapath. Requesters present a vector, a byte count and a direction; the block grants one request per cycle by round-robin and computes the shift with `_mm_slli_si128` / `_mm_srli_si128` semantics. The result is held in an output register with valid/ready backpressure and returned with the requester index.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `TAG_W`, default 4: width of the opaque tag carried from request to result.
- `clk` in 1: single clock, all logic rising-edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_valid` in `NUM_REQ`: per-requester request valid.
- `req_ready` out `NUM_REQ`: per-requester grant. One-hot or zero.
- `req_data` in `NUM_REQ`×128: operand `a`, packed, requester i at `[128*i +: 128]`.
- `req_imm` in `NUM_REQ`×8: byte shift count, unsigned.
- `req_left` in `NUM_REQ`: 1 = slli (toward MSB), 0 = srli (toward LSB).
- `req_tag` in `NUM_REQ`×`TAG_W`: tag, returned unchanged.
- `res_valid` out 1: result register holds a valid result.
- `res_ready` in 1: consumer accepts the result.
- `res_data` out 128: shifted vector.
- `res_id` out `$clog2(NUM_REQ)`: index of the granted requester.
- `res_tag` out `TAG_W`: tag of the granted request.

## Operation
- **Handshake:** a transfer occurs on requester i when `req_valid[i] && req_ready[i]`. The result transfer occurs when `res_valid && res_ready`.
  - A requester must hold its valid, data, imm, left and tag stable until granted.
- **Slot availability:** `slot_free = !res_valid || res_ready`.
  - `req_ready` is all-zero when `!slot_free`.
  - Otherwise exactly one bit of `req_ready` is set, for the first valid requester at or after `rr_ptr`, searching upward with wrap-around.
- **Round-robin pointer:** `rr_ptr` has `$clog2(NUM_REQ)` bits and resets to 0.
  - On a grant to i, `rr_ptr` becomes `(i+1) mod NUM_REQ`.
  - `rr_ptr` holds when there is no grant.
  - `req_ready` is combinational from `req_valid`, `rr_ptr` and `slot_free`. No requester waits more than `NUM_REQ-1` grants.
- **Shift arithmetic:** operates on byte granularity, with byte 0 = bits [7:0].
  - Left: result byte k = a byte (k−imm) if k ≥ imm, else 0.
  - Right: result byte k = a byte (k+imm) if k+imm ≤ 15, else 0.
  - imm ≥ 16 (including 16..255) gives 128'h0. Only imm[7:0] is used; there is no modulo.
- **Output register update:**
  - On a grant, `res_data`, `res_id` and `res_tag` load, and `res_valid` becomes 1.
  - On a drain with no grant, `res_valid` becomes 0. Data holds its last value.
  - Simultaneous drain and grant: the new result replaces the old one, and `res_valid` stays 1.
- **Reset** (synchronous, `rst_n` low at the edge): `res_valid`=0, `res_data`=0, `res_id`=0, `res_tag`=0, `rr_ptr`=0.
  - `req_ready` reads 0 while `rst_n` is low.
  - A result in flight at reset is discarded, not delivered.

## Timing
- Latency is 1 cycle: a request granted at edge N gives `res_valid` high after edge N.
- Throughput is 1 result per cycle when `res_ready` is held high.
- With `res_ready` low and `res_valid` high, all `req_ready` are 0, and the outputs are stable until drained.
- There is no combinational path from `res_ready` to `res_data`. There is a combinational path from `res_ready` to `req_ready`, which is permitted.
- The first grant after reset release is possible in the first cycle with `rst_n` high.

## Structure
- Package `mm_vec_pkg`:
  - `typedef logic [127:0] vec128_t`
  - `localparam VEC_BYTES = 16`
  - `typedef enum logic {SHIFT_RIGHT=0, SHIFT_LEFT=1} shift_dir_t`
- Sub-module `mm_byte_shift128`: combinational. Inputs `a`, `imm`, `dir`; output `dst`. Instantiated once, fed by the granted requester's mux.
- Top level: round-robin arbiter, operand mux, output register.

## Test plan
- **Single right shift:** req0 with a=128'hfafa…fa, imm=15, right -> next cycle res_data=128'h0000…00fa, res_id=0, tag echoed.
- **Left shift and large imm:** req1 with a=128'h00112233445566778899aabbccddeeff, imm=1, left -> res_data=128'h112233445566778899aabbccddeeff00. Then imm=16 and imm=200 -> res_data=0.
- **Round-robin fairness:** all 4 valid continuously, res_ready=1 -> grants 0,1,2,3,0,… with one result per cycle and rr_ptr wrapping from 3 to 0.
- **Backpressure:** res_ready=0 for 5 cycles with req2 valid -> req_ready=0, res_data and res_id stable. Raising res_ready drains the old result and grants req2 on the same edge.
- **Imm=0 passthrough:** both directions -> res_data equals a.
- **Reset mid-operation:** rst_n=0 for one edge while res_valid=1 -> res_valid=0 and rr_ptr=0. After release, the first grant goes to the lowest-index valid requester.

Source files
------------

// File: rtl/mm_vec_pkg.sv
// Shared vector types for the minimap2 SSE-style datapath blocks.
package mm_vec_pkg;
  typedef logic [127:0] vec128_t;
  localparam int VEC_BYTES = 16;
  typedef enum logic {SHIFT_RIGHT = 1'b0, SHIFT_LEFT = 1'b1} shift_dir_t;
endpackage

// File: rtl/mm_byte_shift128.sv
// Combinational 128-bit byte shift with _mm_slli_si128 / _mm_srli_si128 semantics.
import mm_vec_pkg::*;

module mm_byte_shift128 (
  input  vec128_t    a,
  input  logic [7:0] imm,
  input  shift_dir_t dir,
  output vec128_t    dst
);
  logic [6:0] w_bits;

  assign w_bits = {imm[3:0], 3'b000};

  // Counts of 16 or more clear the vector outright; the count never wraps.
  always_comb begin
    dst = '0;
    if (imm < 8'(VEC_BYTES)) begin
      dst = (dir == SHIFT_LEFT) ? (a << w_bits) : (a >> w_bits);
    end
  end
endmodule

// File: rtl/mm_shift_arbiter.sv
// Round-robin sharing of one registered byte-shift unit between NUM_REQ requesters.
import mm_vec_pkg::*;

module mm_shift_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 4,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*128-1:0] req_data,
  input  logic [NUM_REQ*8-1:0]   req_imm,
  input  logic [NUM_REQ-1:0]     req_left,
  input  logic [NUM_REQ*TAG_W-1:0] req_tag,
  output logic                   res_valid,
  input  logic                   res_ready,
  output vec128_t                res_data,
  output logic [ID_W-1:0]        res_id,
  output logic [TAG_W-1:0]       res_tag,
  output logic [ID_W-1:0]        o_dbg_rr_ptr
);
  // Handshake: requester i transfers when req_valid[i] && req_ready[i]; the result
  // transfers when res_valid && res_ready. A requester holds its inputs until granted.
  logic [ID_W-1:0]  r_rr_ptr;
  logic             r_res_valid;
  vec128_t          r_res_data;
  logic [ID_W-1:0]  r_res_id;
  logic [TAG_W-1:0] r_res_tag;

  logic             w_slot_free;
  logic             w_found;
  logic             w_grant;
  logic [ID_W-1:0]  w_gnt_idx;
  logic [ID_W:0]    w_cand;
  vec128_t          w_sel_data;
  logic [7:0]       w_sel_imm;
  logic             w_sel_left;
  logic [TAG_W-1:0] w_sel_tag;
  vec128_t          w_shifted;

  assign w_slot_free = !r_res_valid || res_ready;
  assign w_grant     = w_found && w_slot_free && rst_n;
  assign req_ready   = w_grant ? (NUM_REQ'(1) << w_gnt_idx) : '0;

  // First valid requester at or after the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
      if (w_cand >= (ID_W+1)'(NUM_REQ)) w_cand = w_cand - (ID_W+1)'(NUM_REQ);
      if (!w_found && req_valid[w_cand[ID_W-1:0]]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    w_sel_data = req_data[int'(w_gnt_idx)*128 +: 128];
    w_sel_imm  = req_imm[int'(w_gnt_idx)*8 +: 8];
    w_sel_left = req_left[w_gnt_idx];
    w_sel_tag  = req_tag[int'(w_gnt_idx)*TAG_W +: TAG_W];
  end

  mm_byte_shift128 u_shift (
    .a   (w_sel_data),
    .imm (w_sel_imm),
    .dir (shift_dir_t'(w_sel_left)),
    .dst (w_shifted)
  );

  // A grant on the same edge as a drain simply overwrites the departing result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr_ptr    <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_id    <= '0;
      r_res_tag   <= '0;
    end else if (w_grant) begin
      r_res_valid <= 1'b1;
      r_res_data  <= w_shifted;
      r_res_id    <= w_gnt_idx;
      r_res_tag   <= w_sel_tag;
      r_rr_ptr    <= (w_gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : w_gnt_idx + ID_W'(1);
    end else if (res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

  assign res_valid    = r_res_valid;
  assign res_data     = r_res_data;
  assign res_id       = r_res_id;
  assign res_tag      = r_res_tag;
  assign o_dbg_rr_ptr = r_rr_ptr;
endmodule

// File: tb/tb_mm_shift_arbiter.sv
// Directed plus randomized bench for mm_shift_arbiter against a byte-array reference model.
module tb_mm_shift_arbiter;
  localparam int N  = 4;
  localparam int TW = 4;
  localparam int IW = 2;
  localparam int QW = IW + TW + 128;

  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0]     req_valid, req_ready, req_left;
  logic [N*128-1:0] req_data;
  logic [N*8-1:0]   req_imm;
  logic [N*TW-1:0]  req_tag;
  logic             res_valid, res_ready;
  logic [127:0]     res_data;
  logic [IW-1:0]    res_id, dbg_ptr;
  logic [TW-1:0]    res_tag;

  int n_cmp = 0;
  int n_err = 0;
  logic [QW-1:0] exp_q[$];
  bit m_valid;
  int m_ptr;
  int refill_mode;

  mm_shift_arbiter #(.NUM_REQ(N), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_imm(req_imm), .req_left(req_left), .req_tag(req_tag),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_id(res_id), .res_tag(res_tag), .o_dbg_rr_ptr(dbg_ptr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] ref_shift(input logic [127:0] a, input logic [7:0] imm,
                                             input logic left);
    logic [7:0] b[16];
    logic [127:0] r;
    int src;
    r = '0;
    for (int k = 0; k < 16; k++) b[k] = a[8*k +: 8];
    for (int k = 0; k < 16; k++) begin
      src = left ? k - int'(imm) : k + int'(imm);
      if (src >= 0 && src <= 15) r[8*k +: 8] = b[src];
    end
    return r;
  endfunction

  function automatic int ref_pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [127:0] a, input logic [7:0] imm,
                         input logic left, input logic [TW-1:0] tag);
    req_data[128*i +: 128] = a;
    req_imm[8*i +: 8]      = imm;
    req_left[i]            = left;
    req_tag[TW*i +: TW]    = tag;
    req_valid[i]           = 1'b1;
  endtask

  task automatic new_req(input int i);
    logic [7:0] imm;
    imm = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(16, 255)) : 8'($urandom_range(0, 15));
    set_req(i, {$urandom, $urandom, $urandom, $urandom}, imm, 1'($urandom_range(0, 1)),
            TW'($urandom_range(0, 15)));
  endtask

  // One clock: check grant before the edge, advance the model, check the register after it.
  task automatic cycle(input bit rdy);
    int g;
    logic [N-1:0] exp_rdy;
    bit rst_edge;
    res_ready = rdy;
    #1;
    g = -1;
    if (rst_n && (!m_valid || rdy)) g = ref_pick(req_valid, m_ptr);
    exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
    chk("req_ready", 160'(req_ready), 160'(exp_rdy));
    rst_edge = !rst_n;
    @(posedge clk);
    if (rst_edge) begin
      m_valid = 1'b0;
      m_ptr   = 0;
      exp_q.delete();
    end else begin
      if (m_valid && rdy && exp_q.size() > 0) void'(exp_q.pop_front());
      if (g >= 0) begin
        exp_q.push_back({IW'(g), req_tag[TW*g +: TW],
                         ref_shift(req_data[128*g +: 128], req_imm[8*g +: 8], req_left[g])});
        m_valid = 1'b1;
        m_ptr   = (g + 1) % N;
      end else if (rdy) begin
        m_valid = 1'b0;
      end
    end
    @(negedge clk);
    chk("res_valid", 160'(res_valid), 160'(m_valid));
    chk("rr_ptr", 160'(dbg_ptr), 160'(m_ptr));
    if (rst_edge) chk("reset_regs", 160'({res_id, res_tag, res_data}), 160'(0));
    if (m_valid && exp_q.size() > 0) chk("result", 160'({res_id, res_tag, res_data}), 160'(exp_q[0]));
    if (g >= 0) begin
      case (refill_mode)
        1:       new_req(g);
        2:       if ($urandom_range(0, 1) == 1) new_req(g); else req_valid[g] = 1'b0;
        default: req_valid[g] = 1'b0;
      endcase
    end
  endtask

  initial begin
    rst_n = 1'b0; res_ready = 1'b0; req_valid = '0; req_left = '0;
    req_data = '0; req_imm = '0; req_tag = '0;
    m_valid = 1'b0; m_ptr = 0; refill_mode = 0;
    @(negedge clk);

    // Reset: request pending but no grant may appear while rst_n is low.
    set_req(2, 128'h1, 8'd0, 1'b0, 4'h3);
    cycle(1'b1);
    cycle(1'b1);
    req_valid = '0;
    rst_n = 1'b1;

    // Single right shift by 15.
    set_req(0, {16{8'hfa}}, 8'd15, 1'b0, 4'h5);
    cycle(1'b1);
    chk("right15_data", 160'(res_data), 160'(128'hfa));
    chk("right15_tag", 160'({res_id, res_tag}), 160'({2'd0, 4'h5}));

    // Left shift by 1, then counts of 16 and 200.
    set_req(1, 128'h00112233445566778899aabbccddeeff, 8'd1, 1'b1, 4'h9);
    cycle(1'b1);
    chk("left1_data", 160'(res_data), 160'(128'h112233445566778899aabbccddeeff00));
    set_req(1, 128'h00112233445566778899aabbccddeeff, 8'd16, 1'b1, 4'ha);
    cycle(1'b1);
    chk("left16_zero", 160'(res_data), 160'(0));
    set_req(1, 128'h00112233445566778899aabbccddeeff, 8'd200, 1'b0, 4'hb);
    cycle(1'b1);
    chk("right200_zero", 160'(res_data), 160'(0));

    // Zero count passes the operand through in both directions.
    set_req(3, 128'hdeadbeef_01234567_89abcdef_cafef00d, 8'd0, 1'b1, 4'h1);
    cycle(1'b1);
    chk("imm0_left", 160'(res_data), 160'(128'hdeadbeef_01234567_89abcdef_cafef00d));
    set_req(3, 128'hdeadbeef_01234567_89abcdef_cafef00d, 8'd0, 1'b0, 4'h2);
    cycle(1'b1);
    chk("imm0_right", 160'(res_data), 160'(128'hdeadbeef_01234567_89abcdef_cafef00d));

    // Round-robin with every requester busy and the consumer always ready.
    refill_mode = 1;
    for (int i = 0; i < N; i++) new_req(i);
    for (int c = 0; c < 12; c++) cycle(1'b1);
    refill_mode = 0;
    req_valid = '0;

    // Backpressure: hold a result, keep req2 waiting, then drain and grant together.
    set_req(0, 128'h55, 8'd2, 1'b1, 4'h7);
    cycle(1'b1);
    set_req(2, 128'hff00, 8'd1, 1'b0, 4'hc);
    for (int c = 0; c < 5; c++) cycle(1'b0);
    chk("bp_held_id", 160'(res_id), 160'(0));
    cycle(1'b1);
    chk("bp_grant_id", 160'(res_id), 160'(2));
    chk("bp_grant_data", 160'(res_data), 160'(128'hff));

    // Reset while a result is held; first grant afterwards goes to the lowest valid index.
    set_req(3, 128'h1234, 8'd1, 1'b1, 4'h4);
    set_req(1, 128'h5678, 8'd1, 1'b0, 4'h6);
    rst_n = 1'b0;
    cycle(1'b0);
    rst_n = 1'b1;
    cycle(1'b1);
    chk("post_reset_id", 160'(res_id), 160'(1));

    // Randomized traffic with random consumer backpressure.
    refill_mode = 2;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) if (!req_valid[i] && $urandom_range(0, 2) == 0) new_req(i);
      cycle($urandom_range(0, 3) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
